// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin instruction-fetch arbiter in front of a single shared RAM read port.
// Ports:
//   CLK, RST          clock (rising edge) and synchronous active-high reset
//   iREN[CPUS]        per-CPU fetch request, held until that CPU's iwait goes low
//   iaddr[CPUS*32]    per-CPU fetch address, CPU k at [32k+31:32k]
//   iwait[CPUS]       per-CPU wait, low only in the completion cycle
//   iload[CPUS*32]    per-CPU fetch data, valid while that CPU's iwait is low
//   ramREN, ramaddr   RAM read request and address
//   ramload, ramstate RAM read data and status (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR)
module imem_arbiter #(
    parameter int          CPUS    = 2,
    parameter int          TIMEOUT = 16,
    parameter logic [31:0] BAD     = 32'hBAD1BAD1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CPUS-1:0]     iREN,
    input  logic [CPUS*32-1:0]  iaddr,
    output logic [CPUS-1:0]     iwait,
    output logic [CPUS*32-1:0]  iload,
    output logic                ramREN,
    output logic [31:0]         ramaddr,
    input  logic [31:0]         ramload,
    input  logic [1:0]          ramstate
);
    localparam int OW = CPUS > 1 ? $clog2(CPUS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_q, rr_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] count_q, count_d;
    logic          busy, access, tmo, done, grant;
    logic [OW-1:0] win, rr_next;

    assign busy    = state_q == BUSY;
    assign access  = ramstate == 2'd2;
    assign tmo     = count_q == CW'(TIMEOUT - 1);
    assign done    = busy && (access || tmo);
    assign rr_next = int'(owner_q) == CPUS - 1 ? '0 : owner_q + 1'b1;

    // Scan downward so the requester closest to rr (offset 0) is the last to write win.
    always_comb begin
        grant = 1'b0;
        win   = '0;
        for (int i = CPUS - 1; i >= 0; i--) begin
            if (iREN[(int'(rr_q) + i) % CPUS]) begin
                grant = 1'b1;
                win   = OW'((int'(rr_q) + i) % CPUS);
            end
        end
    end

    // Completion, timeout and withdrawal all end the transaction; only the first two answer the CPU.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        count_d = count_q;
        if (!busy && grant) begin
            state_d = BUSY;
            owner_d = win;
            addr_d  = iaddr[int'(win)*32 +: 32];
            count_d = '0;
        end else if (busy) begin
            state_d = done || !iREN[owner_q] ? IDLE : BUSY;
            rr_d    = done || !iREN[owner_q] ? rr_next : rr_q;
            count_d = done || !iREN[owner_q] ? count_q : count_q + 1'b1;
        end
    end

    always_comb begin
        iwait   = '1;
        iload   = '0;
        ramREN  = busy;
        ramaddr = busy ? addr_q : '0;
        if (done) begin
            iwait[owner_q]                 = 1'b0;
            iload[int'(owner_q)*32 +: 32] = access ? ramload : BAD;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scoreboard bench for imem_arbiter.
module tb_imem_arbiter;
    typedef struct {
        int          cpu;
        logic [31:0] data;
    } exp_t;

    logic        CLK = 0;
    logic        RST = 1;
    logic [1:0]  iREN = '0;
    logic [63:0] iaddr = '0;
    logic [1:0]  iwait;
    logic [63:0] iload;
    logic        ramREN;
    logic [31:0] ramaddr;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = 2'd0;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    imem_arbiter #(.CPUS(2), .TIMEOUT(16), .BAD(32'hBAD1BAD1)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ramREN(ramREN), .ramaddr(ramaddr), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int cpu, input logic [31:0] data);
        exp_t e;
        e.cpu  = cpu;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Entered in an IDLE cycle with the request already driven; leaves in the following IDLE cycle.
    task automatic serve(input int cpu, input logic [31:0] addr, input int nbusy,
                         input logic [31:0] data, input logic [1:0] next_ren);
        tick;
        for (int i = 1; i < nbusy; i++) begin
            ramstate = 2'd1;
            check("ramREN_busy", 64'(ramREN), 64'd1);
            tick;
        end
        ramstate = 2'd2;
        ramload  = data;
        push(cpu, data);
        check("ramaddr", 64'(ramaddr), 64'(addr));
        tick;
        ramstate = 2'd0;
        iREN     = next_ren;
    endtask

    // Monitor: every low iwait bit must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (!RST && iwait != 2'b11) begin
            check("one_low", 64'($countones(~iwait)), 64'd1);
            for (int k = 0; k < 2; k++) begin
                if (!iwait[k]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 64'(k), 64'hFFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("resp_cpu", 64'(k), 64'(e.cpu));
                        check("resp_data", 64'(iload[k*32 +: 32]), 64'(e.data));
                        check("other_iload", 64'(iload[(1-k)*32 +: 32]), 64'd0);
                    end
                end
            end
        end
    end

    initial begin
        tick;
        tick;
        check("rst_iwait", 64'(iwait), 64'h3);
        check("rst_iload", iload, 64'd0);
        check("rst_ramREN", 64'(ramREN), 64'd0);
        check("rst_ramaddr", 64'(ramaddr), 64'd0);
        RST = 0;

        // Single fetch, ACCESS on the first BUSY cycle.
        iREN = 2'b01;
        iaddr[31:0] = 32'h40;
        serve(0, 32'h40, 1, 32'h8C010004, 2'b00);

        // Simultaneous requests rotate 0,1 then wrap back to 0.
        RST = 1;
        tick;
        RST = 0;
        iaddr = {32'h300, 32'h200};
        iREN = 2'b11;
        serve(0, 32'h200, 2, 32'h11110000, 2'b10);
        serve(1, 32'h300, 2, 32'h22220000, 2'b11);
        serve(0, 32'h200, 1, 32'h33330000, 2'b10);
        serve(1, 32'h300, 1, 32'h44440000, 2'b00);

        // Timeout: RAM never answers, BAD returned on the 16th BUSY cycle.
        iaddr[63:32] = 32'h100;
        iREN = 2'b10;
        tick;
        for (int i = 1; i <= 16; i++) begin
            ramstate = i[0] ? 2'd1 : 2'd3;
            check("tmo_ramREN", 64'(ramREN), 64'd1);
            check("tmo_ramaddr", 64'(ramaddr), 64'h100);
            if (i == 16) push(1, 32'hBAD1BAD1);
            tick;
        end
        ramstate = 2'd0;
        iREN = 2'b00;
        check("tmo_idle", 64'(ramREN), 64'd0);

        // Withdrawal on the third BUSY cycle, then pending CPU1 is granted.
        iaddr = {32'h500, 32'h400};
        iREN = 2'b11;
        tick;
        ramstate = 2'd1;
        tick;
        tick;
        iREN = 2'b10;
        check("wd_ramREN", 64'(ramREN), 64'd1);
        tick;
        check("wd_idle", 64'(ramREN), 64'd0);
        serve(1, 32'h500, 1, 32'h55550000, 2'b00);

        // Reset mid-BUSY aborts and returns rr to 0.
        iREN = 2'b01;
        serve(0, 32'h400, 1, 32'h66660000, 2'b10);
        tick;
        ramstate = 2'd1;
        check("pre_rst_addr", 64'(ramaddr), 64'h500);
        RST = 1;
        tick;
        RST = 0;
        iREN = 2'b00;
        ramstate = 2'd2;
        check("abort_iwait", 64'(iwait), 64'h3);
        check("abort_ramREN", 64'(ramREN), 64'd0);
        tick;
        check("abort_iwait2", 64'(iwait), 64'h3);
        ramstate = 2'd0;
        iREN = 2'b11;
        serve(0, 32'h400, 1, 32'h77770000, 2'b10);
        serve(1, 32'h500, 1, 32'h88880000, 2'b00);

        // Address change after grant is ignored.
        iaddr[31:0] = 32'h40;
        iREN = 2'b01;
        tick;
        ramstate = 2'd1;
        check("hold_addr1", 64'(ramaddr), 64'h40);
        iaddr[31:0] = 32'h80;
        tick;
        check("hold_addr2", 64'(ramaddr), 64'h40);
        ramstate = 2'd2;
        ramload = 32'h99990000;
        push(0, 32'h99990000);
        check("hold_addr3", 64'(ramaddr), 64'h40);
        tick;
        ramstate = 2'd0;
        iREN = 2'b00;
        tick;
        tick;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
